sram_bus_tester: RTL and testbench

SRAM_BUS_TESTER -- requirements
Module: sram_bus_tester

---
 rtl/sram_test_pkg.sv | 47 ++++
 rtl/sram_test_lfsr.sv | 23 ++
 rtl/sram_bus_tester.sv | 176 +++++++++++++++++
 tb/tb_sram_bus_tester.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_test_pkg.sv
// Shared types, constants and helpers for the SRAM bus tester.
package sram_test_pkg;

  localparam int unsigned ADDR_W     = 9;
  localparam int unsigned BUS_ADDR_W = 10;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned ERR_W      = 10;

  // One-hot controller states.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_WRITE  = 4'b0010,
    ST_READ   = 4'b0100,
    ST_FINISH = 4'b1000
  } state_t;

  // Data pattern selection codes.
  typedef enum logic [1:0] {
    PAT_ADDR    = 2'd0,
    PAT_NADDR   = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_LFSR    = 2'd3
  } pattern_t;

  localparam logic [DATA_W-1:0] LFSR_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11+1 in right-shift form feeds back bits 0,2,3,5.
  localparam logic [DATA_W-1:0] LFSR_TAP_MASK = 16'h002D;

  // One Fibonacci LFSR step.
  function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] v);
    lfsr_next = {^(v & LFSR_TAP_MASK), v[DATA_W-1:1]};
  endfunction

  // Data word for a given address under the selected pattern.
  function automatic logic [DATA_W-1:0] pattern_word(input pattern_t sel,
                                                     input logic [ADDR_W-1:0] addr,
                                                     input logic [DATA_W-1:0] lfsr);
    pattern_word = lfsr;
    case (sel)
      PAT_ADDR:    pattern_word = DATA_W'(addr);
      PAT_NADDR:   pattern_word = ~DATA_W'(addr);
      PAT_CHECKER: pattern_word = addr[0] ? 16'hAAAA : 16'h5555;
      default:     pattern_word = lfsr;
    endcase
  endfunction

endpackage

// File: rtl/sram_test_lfsr.sv
// Pattern LFSR: reloadable to the seed, advances one step per completed access.
module sram_test_lfsr
  import sram_test_pkg::*;
(
  input  logic              clock,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  output logic [DATA_W-1:0] value
);

  // Seed load has priority over stepping.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      value <= LFSR_SEED;
    end else if (load) begin
      value <= LFSR_SEED;
    end else if (step) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/sram_bus_tester.sv
// SRAM bus tester: writes a pattern over 0..ADDR_LAST, reads it back, reports errors.
module sram_bus_tester
  import sram_test_pkg::*;
#(
  parameter logic [8:0]  ADDR_LAST = 9'd511,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            pattern_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [ERR_W-1:0]      err_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic [BUS_ADDR_W-1:0] address_bus,
  output logic [1:0]            byteena_bus,
  output logic [DATA_W-1:0]     data_bus,
  output logic                  wren_bus,
  output logic                  ce_bus,
  input  logic [DATA_W-1:0]     q_bus,
  input  logic                  wait_bus
);

  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t              state_q, state_d;
  pattern_t            sel_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [DATA_W-1:0]   lfsr_value;
  logic                lfsr_load, lfsr_step;
  logic                stall, complete, wait_expired, last_addr;
  logic [DATA_W-1:0]   exp_word, next_word;

  assign address_bus = {1'b0, addr_q};
  assign byteena_bus = 2'b11;

  // Access handshake decode; wait_bus only matters while ce_bus is high.
  always_comb begin
    stall        = ce_bus & wait_bus;
    complete     = ce_bus & ~wait_bus;
    wait_expired = stall && (wait_cnt == WAIT_W'(TIMEOUT - 1));
    last_addr    = (addr_q == ADDR_LAST);
    exp_word     = pattern_word(sel_q, addr_q, lfsr_value);
    next_word    = pattern_word(sel_q, addr_q + 9'd1, lfsr_next(lfsr_value));
  end

  sram_test_lfsr u_lfsr (
    .clock (clock),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .value (lfsr_value)
  );

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and LFSR control; reseeding at each phase entry replays the write sequence.
  always_comb begin
    state_d   = state_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_WRITE;
          lfsr_load = 1'b1;
        end
      end
      ST_WRITE: begin
        if (wait_expired) begin
          state_d = ST_IDLE;
        end else if (complete) begin
          lfsr_step = 1'b1;
          if (last_addr) begin
            state_d   = ST_READ;
            lfsr_load = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (wait_expired) begin
          state_d = ST_IDLE;
        end else if (complete) begin
          lfsr_step = 1'b1;
          if (last_addr) state_d = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Consecutive stalled cycles of the current access.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)                      wait_cnt <= '0;
    else if (stall && !wait_expired) wait_cnt <= wait_cnt + WAIT_W'(1);
    else                             wait_cnt <= '0;
  end

  // Bus drive, error tracking and result flags.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sel_q          <= PAT_ADDR;
      addr_q         <= '0;
      data_bus       <= '0;
      wren_bus       <= 1'b0;
      ce_bus         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sel_q          <= pattern_t'(pattern_sel);
            addr_q         <= '0;
            data_bus       <= pattern_word(pattern_t'(pattern_sel), '0, LFSR_SEED);
            wren_bus       <= 1'b1;
            ce_bus         <= 1'b1;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
          end
        end
        ST_WRITE, ST_READ: begin
          if (wait_expired) begin
            ce_bus   <= 1'b0;
            wren_bus <= 1'b0;
            busy     <= 1'b0;
            timeout  <= 1'b1;
            done     <= 1'b1;
            pass     <= 1'b0;
          end else if (complete) begin
            if (state_q == ST_READ && q_bus != exp_word) begin
              if (err_count == '0)     first_err_addr <= addr_q;
              if (err_count != ERR_MAX) err_count     <= err_count + ERR_W'(1);
            end
            if (last_addr) begin
              // ce and wren fall together so wren never moves under an active access.
              ce_bus   <= 1'b0;
              wren_bus <= 1'b0;
              addr_q   <= '0;
            end else begin
              addr_q   <= addr_q + 9'd1;
              data_bus <= next_word;
            end
          end else if (state_q == ST_READ && !ce_bus) begin
            ce_bus <= 1'b1;
          end
        end
        ST_FINISH: begin
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (err_count == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_tester.sv
// Bench for sram_bus_tester: behavioural two-state SRAM responder, scoreboard and bus monitor.
module tb_sram_bus_tester;

  localparam int unsigned TO     = 16;
  localparam int unsigned NWORDS = 512;
  localparam int          BUDGET = 5000;

  logic        clock, rst_n, start;
  logic [1:0]  pattern_sel;
  logic        busy, done, pass, timeout;
  logic [9:0]  err_count;
  logic [8:0]  first_err_addr;
  logic [9:0]  address_bus;
  logic [1:0]  byteena_bus;
  logic [15:0] data_bus, q_bus;
  logic        wren_bus, ce_bus, wait_bus;

  sram_bus_tester #(.ADDR_LAST(9'd511), .TIMEOUT(TO)) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .pattern_sel(pattern_sel),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .address_bus(address_bus), .byteena_bus(byteena_bus), .data_bus(data_bus),
    .wren_bus(wren_bus), .ce_bus(ce_bus), .q_bus(q_bus), .wait_bus(wait_bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Responder: first cycle of every access stalls, second completes.
  logic [15:0] mem [0:NWORDS-1];
  logic        phase;
  logic        force_wait, fault_en, fault_val;
  logic [8:0]  fault_addr;
  int          fault_bit;

  assign wait_bus = force_wait | (ce_bus & ~phase);

  always @(posedge clock) begin
    if (ce_bus && !wait_bus) begin
      phase <= 1'b0;
      if (wren_bus) mem[address_bus[8:0]] <= data_bus;
    end else if (ce_bus) begin
      phase <= 1'b1;
    end else begin
      phase <= 1'b0;
    end
  end

  always @* begin
    q_bus = mem[address_bus[8:0]];
    if (fault_en && address_bus[8:0] == fault_addr) q_bus[fault_bit] = fault_val;
  end

  // Reference model
  typedef struct {
    bit tmo;
    bit pas;
    int errs;
    int first;
  } res_t;

  res_t        exp_q[$];
  logic [15:0] lfsr_seq [0:NWORDS-1];
  int          checks = 0;
  int          failures = 0;
  int          cur_sel;

  function automatic logic [15:0] model_word(input int sel, input int a);
    case (sel)
      0:       return 16'(a);
      1:       return ~16'(a);
      2:       return (a % 2 == 1) ? 16'hAAAA : 16'h5555;
      default: return lfsr_seq[a];
    endcase
  endfunction

  function automatic res_t compute_result(input int sel, input bit fen, input int faddr,
                                          input int fbit, input bit fval);
    res_t        r;
    logic [15:0] w, rd;
    r.tmo = 0; r.errs = 0; r.first = 0;
    for (int a = 0; a < int'(NWORDS); a++) begin
      w  = model_word(sel, a);
      rd = w;
      if (fen && a == faddr) rd[fbit] = fval;
      if (rd != w) begin
        if (r.errs == 0) r.first = a;
        if (r.errs < 1023) r.errs++;
      end
    end
    r.pas = (r.errs == 0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ce"}, 32'(ce_bus), 32'd0);
    chk({tag, "_wren"}, 32'(wren_bus), 32'd0);
    chk({tag, "_addr"}, 32'(address_bus), 32'd0);
    chk({tag, "_data"}, 32'(data_bus), 32'd0);
    chk({tag, "_byteena"}, 32'(byteena_bus), 32'd3);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_errs"}, 32'(err_count), 32'd0);
    chk({tag, "_first"}, 32'(first_err_addr), 32'd0);
  endtask

  // Monitor: protocol rules, per-access address/data, and result scoreboard.
  task automatic monitor();
    logic        p_ce = 0, p_wait = 0, p_wren = 0, p_done = 0;
    logic [9:0]  p_addr = 0;
    logic [15:0] p_data = 0;
    int          acc = 0, gap = 0, a;
    res_t        r;
    forever begin
      @(negedge clock);
      if (!busy) begin acc = 0; gap = 0; end
      if (rst_n && p_ce && p_wait && ce_bus) begin
        chk("stall_addr", 32'(address_bus), 32'(p_addr));
        chk("stall_data", 32'(data_bus), 32'(p_data));
        chk("stall_wren", 32'(wren_bus), 32'(p_wren));
      end else if (rst_n && p_ce && ce_bus) begin
        chk("wren_stable", 32'(wren_bus), 32'(p_wren));
      end
      if (busy && !ce_bus) gap++;
      else if (busy && ce_bus && gap > 0) begin
        chk("phase_gap", 32'(gap), 32'd1);
        gap = 0;
      end
      if (busy && ce_bus && !wait_bus) begin
        a = acc % int'(NWORDS);
        chk("acc_addr", 32'(address_bus), 32'(a));
        chk("acc_wren", 32'(wren_bus), 32'(acc < int'(NWORDS)));
        if (acc < int'(NWORDS)) chk("wr_data", 32'(data_bus), 32'(model_word(cur_sel, a)));
        acc++;
      end
      if (done && !p_done) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          r = exp_q.pop_front();
          chk("res_timeout", 32'(timeout), 32'(r.tmo));
          chk("res_pass", 32'(pass), 32'(r.pas));
          chk("res_errs", 32'(err_count), 32'(r.errs));
          chk("res_first", 32'(first_err_addr), 32'(r.first));
        end
      end
      p_ce = ce_bus; p_wait = wait_bus; p_wren = wren_bus; p_done = done;
      p_addr = address_bus; p_data = data_bus;
    end
  endtask

  // Launch one test; optionally glitch start/pattern_sel mid-run. Returns cycles to done.
  task automatic run_test(input int sel, input bit fen, input int faddr, input int fbit,
                          input bit fval, input int glitch_at, output int cyc);
    fault_en = fen; fault_addr = 9'(faddr); fault_bit = fbit; fault_val = fval;
    cur_sel = sel;
    exp_q.push_back(compute_result(sel, fen, faddr, fbit, fval));
    @(posedge clock); #1 pattern_sel = 2'(sel); start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    cyc = 0;
    while (cyc < BUDGET) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("done_cleared", 32'(done), 32'd0);
      end
      if (glitch_at > 0 && cyc == glitch_at) begin
        start = 1'b1; pattern_sel = 2'((sel + 1) % 4);
      end
      if (glitch_at > 0 && cyc == glitch_at + 1) start = 1'b0;
      if (done) break;
    end
    start = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL done_wait actual=not_done required=done after %0d cycles", cyc);
    end
    repeat (2) @(negedge clock);
  endtask

  initial begin
    int          cyc, bad, found;
    logic [15:0] v;
    rst_n = 1'b0; start = 1'b0; pattern_sel = 2'd0;
    force_wait = 1'b0; fault_en = 1'b0; fault_val = 1'b0; fault_addr = '0; fault_bit = 0;
    cur_sel = 0;
    v = 16'hACE1;
    for (int i = 0; i < int'(NWORDS); i++) begin
      lfsr_seq[i] = v;
      v = {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    end
    fork
      monitor();
    join_none

    repeat (3) @(negedge clock);
    check_reset("por");
    @(posedge clock); #1 rst_n = 1'b1;

    // Address pattern, fault-free
    run_test(0, 0, 0, 0, 0, 0, cyc);
    chk("s1_cycles", 32'(cyc), 32'(4 * NWORDS + 3));

    // LFSR pattern, bit 5 stuck low at 0x07F
    run_test(3, 1, 'h7F, 5, 0, 0, cyc);

    // Responder stuck in wait
    force_wait = 1'b1; fault_en = 1'b0; cur_sel = 0;
    exp_q.push_back('{tmo: 1, pas: 0, errs: 0, first: 0});
    @(posedge clock); #1 pattern_sel = 2'd0; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    bad = 0;
    for (int n = 1; n <= int'(TO) + 1; n++) begin
      @(negedge clock);
      if (n <= int'(TO)) begin
        if (!ce_bus) bad++;
      end else begin
        chk("to_ce_low", 32'(ce_bus), 32'd0);
        chk("to_flag", 32'(timeout), 32'd1);
        chk("to_done", 32'(done), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
      end
    end
    chk("to_ce_held", 32'(bad), 32'd0);
    found = 0;
    repeat (30) begin
      @(negedge clock);
      if (ce_bus) found = 1;
    end
    chk("to_no_access", 32'(found), 32'd0);
    force_wait = 1'b0;

    // Reset in the middle of the write phase, then a checkerboard rerun
    cur_sel = 1;
    @(posedge clock); #1 pattern_sel = 2'd1; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      @(negedge clock);
      if (ce_bus && wren_bus && address_bus == 10'd100) found = 1;
    end
    chk("reach_addr100", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset("mid");
    bad = 0;
    repeat (3) begin
      @(negedge clock);
      if (ce_bus) bad++;
    end
    chk("mid_no_bus", 32'(bad), 32'd0);
    @(posedge clock); #1 rst_n = 1'b1;
    run_test(2, 0, 0, 0, 0, 0, cyc);
    chk("s4_word0", 32'(mem[0]), 32'h5555);
    chk("s4_word1", 32'(mem[1]), 32'hAAAA);

    // start and pattern_sel disturbed mid-test; result follows the captured sel
    run_test(1, 1, int'($urandom_range(511, 0)), int'($urandom_range(15, 0)),
             1'($urandom_range(1, 0)), 300, cyc);
    repeat (50) @(negedge clock);
    chk("s5_no_restart", 32'(busy), 32'd0);
    chk("s5_done_held", 32'(done), 32'd1);
    chk("s5_queue_empty", 32'(exp_q.size()), 32'd0);

    // Random patterns and faults
    for (int k = 0; k < 3; k++) begin
      run_test(int'($urandom_range(3, 0)), 1, int'($urandom_range(511, 0)),
               int'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), 0, cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
